// File: rtl/dl_sampler_pkg.sv
// Shared types and helpers for the multi-channel delay-line sampler.
package dl_sampler_pkg;

  typedef enum logic [3:0] {
    OP_LOAD   = 4'd0,
    OP_UNLOAD = 4'd1,
    OP_SAMPLE = 4'd2,
    OP_EDGE   = 4'd3,
    OP_COUNT  = 4'd4
  } op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CAP  = 2'd1,
    EVAL = 2'd2,
    HOLD = 2'd3
  } state_e;

  // Width for a counter holding 0..win_len-1, never narrower than one bit.
  function automatic int unsigned win_cnt_width(input int unsigned win_len);
    return (win_len < 2) ? 1 : $clog2(win_len);
  endfunction

endpackage

// File: rtl/dl_sampler_reduce.sv
// Combinational reduction of a delay-line sample to edge position and transition count.
module dl_sampler_reduce #(
  parameter int unsigned DL_W = 32
) (
  input  logic [DL_W-1:0] data,
  output logic [7:0]      edge_pos,
  output logic [7:0]      trans_cnt
);

  // Ascending scan: the last matching falling step wins, giving the highest one.
  always_comb begin
    edge_pos  = '0;
    trans_cnt = '0;
    for (int unsigned j = 0; j < DL_W - 1; j++) begin
      if (data[j] && !data[j+1]) begin
        edge_pos = 8'(j + 1);
      end
      trans_cnt = trans_cnt + 8'(data[j] ^ data[j+1]);
    end
  end

endmodule

// File: rtl/dl_sampler.sv
// Byte-command driven delay-line sampler: load/unload shift register, channel capture, reduction.
module dl_sampler
  import dl_sampler_pkg::*;
#(
  parameter int unsigned DL_W    = 32,
  parameter int unsigned NUM_CH  = 4,
  parameter int unsigned CAP_WIN = 2
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_valid,
  input  logic [7:0]             i_data,
  output logic                   o_valid,
  input  logic                   i_accept,
  output logic [7:0]             o_data,
  input  logic [NUM_CH-1:0]      i_dl_valid,
  input  logic [NUM_CH*DL_W-1:0] i_dl
);

  localparam int unsigned       WIN_W    = win_cnt_width(CAP_WIN);
  localparam logic [WIN_W-1:0]  WIN_LAST = WIN_W'(CAP_WIN - 1);

  state_e            state_q, state_d;
  op_e               op_q, op_d;
  logic [3:0]        ch_q, ch_d;
  logic [WIN_W-1:0]  win_q, win_d;
  logic              got_q, got_d;
  logic [DL_W-1:0]   data_q, data_d;

  op_e               cmd_op;
  logic [3:0]        cmd_arg;
  logic              arg_ok;
  logic [3:0]        sel;
  logic              sel_valid;
  logic [DL_W-1:0]   sel_sample;
  logic [7:0]        edge_pos;
  logic [7:0]        trans_cnt;
  logic [7:0]        result;

  assign cmd_op  = op_e'(i_data[3:0]);
  assign cmd_arg = i_data[7:4];
  assign arg_ok  = 32'(cmd_arg) < NUM_CH;
  assign result  = (op_q == OP_EDGE) ? edge_pos : trans_cnt;
  assign o_data  = data_q[DL_W-1 -: 8];
  assign o_valid = (state_q == HOLD);

  // Channel mux: the command argument selects on the command cycle, the latched channel afterwards.
  always_comb begin
    sel        = (state_q == IDLE) ? cmd_arg : ch_q;
    sel_valid  = 1'b0;
    sel_sample = '0;
    for (int unsigned c = 0; c < NUM_CH; c++) begin
      if (sel == 4'(c)) begin
        sel_valid  = i_dl_valid[c];
        sel_sample = i_dl[c*DL_W +: DL_W];
      end
    end
  end

  dl_sampler_reduce #(
    .DL_W (DL_W)
  ) u_reduce (
    .data      (data_q),
    .edge_pos  (edge_pos),
    .trans_cnt (trans_cnt)
  );

  // Next-state and datapath update; the command cycle is window cycle 0, so a one-cycle
  // window skips CAP entirely.
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    ch_d    = ch_q;
    win_d   = win_q;
    got_d   = got_q;
    data_d  = data_q;
    case (state_q)
      IDLE: begin
        if (i_valid) begin
          case (cmd_op)
            OP_LOAD:   data_d  = (data_q << 4) | DL_W'(cmd_arg);
            OP_UNLOAD: state_d = HOLD;
            OP_SAMPLE, OP_EDGE, OP_COUNT: begin
              if (arg_ok) begin
                ch_d  = cmd_arg;
                op_d  = cmd_op;
                win_d = WIN_W'(1);
                got_d = sel_valid;
                if (sel_valid) begin
                  data_d = sel_sample;
                end
                if (CAP_WIN == 1) begin
                  state_d = (cmd_op == OP_SAMPLE) ? IDLE : EVAL;
                end else begin
                  state_d = CAP;
                end
              end
            end
            default: ;
          endcase
        end
      end
      CAP: begin
        if (!got_q && sel_valid) begin
          data_d = sel_sample;
          got_d  = 1'b1;
        end
        if (win_q == WIN_LAST) begin
          state_d = (op_q == OP_SAMPLE) ? IDLE : EVAL;
        end else begin
          win_d = win_q + WIN_W'(1);
        end
      end
      EVAL: begin
        data_d  = DL_W'(result) << (DL_W - 8);
        state_d = HOLD;
      end
      HOLD: begin
        if (i_accept) begin
          data_d  = data_q << 8;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and data registers with synchronous reset.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= IDLE;
      op_q    <= OP_LOAD;
      ch_q    <= '0;
      win_q   <= '0;
      got_q   <= 1'b0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      ch_q    <= ch_d;
      win_q   <= win_d;
      got_q   <= got_d;
      data_q  <= data_d;
    end
  end

endmodule

// File: tb/tb_dl_sampler.sv
// Self-checking bench for dl_sampler: directed scenarios then randomized commands against a word-level model.
module tb_dl_sampler;

  localparam int unsigned DL_W    = 32;
  localparam int unsigned NUM_CH  = 4;
  localparam int unsigned CAP_WIN = 2;

  logic                   clk = 1'b0;
  logic                   i_rst;
  logic                   i_valid;
  logic [7:0]             i_data;
  logic                   o_valid;
  logic                   i_accept;
  logic [7:0]             o_data;
  logic [NUM_CH-1:0]      i_dl_valid;
  logic [NUM_CH*DL_W-1:0] i_dl;

  always #5 clk = ~clk;

  dl_sampler #(
    .DL_W    (DL_W),
    .NUM_CH  (NUM_CH),
    .CAP_WIN (CAP_WIN)
  ) dut (
    .i_clk      (clk),
    .i_rst      (i_rst),
    .i_valid    (i_valid),
    .i_data     (i_data),
    .o_valid    (o_valid),
    .i_accept   (i_accept),
    .o_data     (o_data),
    .i_dl_valid (i_dl_valid),
    .i_dl       (i_dl)
  );

  int unsigned tests = 0;
  int unsigned fails = 0;
  logic [31:0] model;
  logic [31:0] sw [3][4];
  logic [3:0]  sv [3];

  // Reference reductions written from the definitions.
  function automatic logic [31:0] ref_edge(input logic [31:0] x);
    for (int p = 31; p >= 1; p--) begin
      if (x[p-1] == 1'b1 && x[p] == 1'b0) return 32'(p);
    end
    return 32'd0;
  endfunction

  function automatic logic [31:0] ref_count(input logic [31:0] x);
    logic [31:0] t;
    t = (x ^ (x >> 1)) & 32'h7FFF_FFFF;
    return 32'($countones(t));
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_out(input string tag, input logic exp_valid);
    check({tag, "_v"}, 32'(o_valid), 32'(exp_valid));
    check({tag, "_d"}, 32'(o_data), 32'(model[31:24]));
  endtask

  task automatic apply_phase(input int k);
    i_dl_valid = sv[k];
    for (int c = 0; c < 4; c++) i_dl[c*32 +: 32] = sw[k][c];
  endtask

  task automatic clear_stim;
    for (int k = 0; k < 3; k++) begin
      sv[k] = 4'b0;
      for (int c = 0; c < 4; c++) sw[k][c] = $urandom;
    end
  endtask

  task automatic do_load(input logic [3:0] arg);
    i_valid = 1'b1;
    i_data  = {arg, 4'd0};
    tick;
    i_valid = 1'b0;
    model = {model[27:0], arg};
    check_out("load", 1'b0);
  endtask

  task automatic accept_byte;
    i_accept = 1'b1;
    tick;
    i_accept = 1'b0;
    model = model << 8;
    check_out("accept", 1'b0);
  endtask

  task automatic do_unload;
    i_valid = 1'b1;
    i_data  = {4'd0, 4'd1};
    tick;
    i_valid = 1'b0;
    check_out("unload", 1'b1);
    accept_byte;
  endtask

  // Issues a capture command with sv/sw as the per-cycle channel stimulus (cycles 0,1,2).
  // Leaves the DUT in HOLD for a valid EDGE/COUNT.
  task automatic capture(input logic [3:0] op, input logic [3:0] arg);
    bit active;
    active = (arg < NUM_CH) && (op >= 4'd2) && (op <= 4'd4);
    if (active) begin
      for (int k = 0; k < CAP_WIN; k++) begin
        if (sv[k][arg]) begin
          model = sw[k][arg];
          break;
        end
      end
    end
    i_valid = 1'b1;
    i_data  = {arg, op};
    apply_phase(0);
    tick;
    i_valid = 1'b0;
    apply_phase(1);
    tick;
    check("cap_busy_v", 32'(o_valid), 32'd0);
    apply_phase(2);
    tick;
    i_dl_valid = '0;
    if (active && op != 4'd2) begin
      model = (op == 4'd3) ? (ref_edge(model) << 24) : (ref_count(model) << 24);
      check_out("cap_res", 1'b1);
    end else begin
      check_out("cap", 1'b0);
    end
  endtask

  initial begin
    logic [31:0] keep;
    int unsigned sel;
    logic [3:0]  arg;
    i_rst = 1'b1; i_valid = 1'b0; i_data = '0; i_accept = 1'b0;
    i_dl_valid = '0; i_dl = '0;
    model = '0;
    clear_stim;
    tick; tick;
    i_rst = 1'b0;
    check_out("reset", 1'b0);

    // LOAD 8..1 then read back
    for (int a = 8; a >= 1; a--) do_load(4'(a));
    check("load_word_top", 32'(o_data), 32'h87);
    for (int i = 0; i < 5; i++) do_unload;
    check("drained", 32'(o_data), 32'h00);

    // SAMPLE ch2: first valid in window wins; valid after window ignored
    clear_stim;
    sv[1] = 4'b0100; sw[1][2] = 32'hDEADBEEF;
    sv[2] = 4'b0100; sw[2][2] = 32'h12345678;
    capture(4'd2, 4'd2);
    check("sample_top", 32'(o_data), 32'hDE);
    for (int i = 0; i < 4; i++) do_unload;

    // Both window cycles valid: cycle 0 sample kept
    clear_stim;
    sv[0] = 4'b0100; sw[0][2] = 32'hCAFEF00D;
    sv[1] = 4'b0100; sw[1][2] = 32'h11111111;
    capture(4'd2, 4'd2);
    check("sample_c0", 32'(o_data), 32'hCA);

    // Only channel 1 valid: ch2 data unchanged
    do_load(4'hA); do_load(4'h5);
    keep = model;
    clear_stim;
    sv[0] = 4'b0010; sv[1] = 4'b0010;
    capture(4'd2, 4'd2);
    check("sample_nochg", model, keep);
    for (int i = 0; i < 4; i++) do_unload;

    // EDGE ch0
    clear_stim; sv[0] = 4'b0001; sw[0][0] = 32'h0000FFFF;
    capture(4'd3, 4'd0); check("edge_ffff", 32'(o_data), 32'h10); accept_byte;
    clear_stim; sv[1] = 4'b0001; sw[1][0] = 32'hFFFFFFFF;
    capture(4'd3, 4'd0); check("edge_all1", 32'(o_data), 32'h00); accept_byte;
    clear_stim; sv[0] = 4'b0001; sw[0][0] = 32'h00000001;
    capture(4'd3, 4'd0); check("edge_one", 32'(o_data), 32'h01); accept_byte;

    // COUNT ch3
    clear_stim; sv[0] = 4'b1000; sw[0][3] = 32'h0F0F0F0F;
    capture(4'd4, 4'd3); check("count_0f", 32'(o_data), 32'h07); accept_byte;
    clear_stim; sv[1] = 4'b1000; sw[1][3] = 32'hAAAAAAAA;
    capture(4'd4, 4'd3); check("count_aa", 32'(o_data), 32'h1F);

    // Busy: commands in HOLD dropped
    keep = model;
    i_valid = 1'b1; i_data = {4'h5, 4'd0}; tick; i_valid = 1'b0;
    check_out("hold_load", 1'b1);
    clear_stim; sv[0] = 4'b1111; sv[1] = 4'b1111;
    i_valid = 1'b1; i_data = {4'd0, 4'd2}; apply_phase(0); tick;
    i_valid = 1'b0; apply_phase(1); tick; i_dl_valid = '0;
    check_out("hold_sample", 1'b1);
    check("hold_keep", model, keep);
    // Accept and command together: accept wins, command dropped
    i_valid = 1'b1; i_data = {4'h9, 4'd0}; i_accept = 1'b1; tick;
    i_valid = 1'b0; i_accept = 1'b0;
    model = model << 8;
    check_out("acc_cmd", 1'b0);
    do_load(4'h7);

    // Out-of-range channel and unused opcode dropped; stray accept ignored
    clear_stim; sv[0] = 4'b1111; sv[1] = 4'b1111;
    capture(4'd2, 4'd7);
    capture(4'd3, 4'd9);
    i_valid = 1'b1; i_data = {4'h3, 4'd9}; tick; i_valid = 1'b0;
    check_out("op9", 1'b0);
    i_accept = 1'b1; tick; i_accept = 1'b0;
    check_out("stray_acc", 1'b0);

    // Reset during capture
    clear_stim; sv[1] = 4'b0010;
    i_valid = 1'b1; i_data = {4'd1, 4'd3}; tick; i_valid = 1'b0;
    apply_phase(1); i_rst = 1'b1; tick; i_rst = 1'b0; i_dl_valid = '0;
    model = '0;
    check_out("rst_cap", 1'b0);
    tick;
    check_out("rst_cap_idle", 1'b0);
    do_unload;

    // Reset during hold
    do_load(4'h3);
    i_valid = 1'b1; i_data = {4'd0, 4'd1}; tick; i_valid = 1'b0;
    check_out("pre_rst_hold", 1'b1);
    i_rst = 1'b1; tick; i_rst = 1'b0;
    model = '0;
    check_out("rst_hold", 1'b0);
    do_unload;

    // Randomized command stream
    for (int it = 0; it < 80; it++) begin
      sel = $urandom_range(0, 7);
      case (sel)
        0, 1: do_load(4'($urandom));
        2:    do_unload;
        3, 4, 5: begin
          clear_stim;
          for (int k = 0; k < 3; k++) sv[k] = 4'($urandom);
          arg = 4'($urandom_range(0, 5));
          capture(4'(sel - 1), arg);
          if (sel != 3 && arg < NUM_CH) accept_byte;
        end
        default: begin
          i_valid = 1'b1; i_data = {4'($urandom), 4'($urandom_range(5, 15))}; tick; i_valid = 1'b0;
          check_out("rnd_ign", 1'b0);
        end
      endcase
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/dl_sampler.md
# dl_sampler

Parametrised multi-channel successor to the single-channel delay-line driver. Decodes byte commands from the UART RX path and loads or unloads a DL_W-bit shift register through the TX handshake. Captures a full sample from one of NUM_CH delay lines, or reduces it to a one-byte edge position or transition count. Sits between the UART RX/TX pair and the delay-line instances.

## Interface
- DL_W, 32, delay-line width in bits; multiple of 8, range 8..128.
- NUM_CH, 4, number of delay-line channels; range 1..16.
- CAP_WIN, 2, capture window length in cycles; range 1..15.
- i_clk  in  1  clock.
- i_rst  in  1  reset, synchronous, active-high.
- i_valid  in  1  RX byte valid, single-cycle pulse.
- i_data  in  8  RX byte: [3:0] opcode, [7:4] argument.
- o_valid  out  1  TX byte valid, held until accepted.
- i_accept  in  1  TX accepted the current byte.
- o_data  out  8  TX byte, always data_q[DL_W-1 -: 8].
- i_dl_valid  in  NUM_CH  per-channel sample valid.
- i_dl  in  NUM_CH*DL_W  channel c occupies bits [c*DL_W +: DL_W].

## Operation
- Opcodes:
  - 0 LOAD: data_q <= {data_q[DL_W-5:0], arg}.
  - 1 UNLOAD: present the top byte.
  - 2 SAMPLE ch=arg: capture channel arg.
  - 3 EDGE ch=arg: capture channel arg, then send its edge position.
  - 4 COUNT ch=arg: capture channel arg, then send its transition count.
  - 5..15: ignored.
- Busy rule: a command arriving in any state other than IDLE is dropped, with no side effect.
- Channel rule: arg >= NUM_CH on opcodes 2..4 means the command is dropped.
- FSM states:
  - IDLE. LOAD applies in place. UNLOAD goes to HOLD. 2/3/4 latch ch and op, clear the window counter, and go to CAP.
  - CAP. Lasts CAP_WIN cycles, counting the command cycle as cycle 0. In the first window cycle with i_dl_valid[ch]=1, data_q <= channel sample; later valids in the same window are ignored. If no valid arrives, data_q is unchanged. At window end: SAMPLE goes to IDLE; EDGE/COUNT go to EVAL.
  - EVAL. One cycle. Writes data_q <= {result[7:0], (DL_W-8)'b0} and sets o_valid. Goes to HOLD.
  - HOLD. o_valid=1. On i_accept: data_q <= {data_q[DL_W-9:0], 8'h00}, o_valid cleared, go to IDLE.
- i_accept outside HOLD is ignored.
- Edge position = j+1 for the highest j in 0..DL_W-2 with data_q[j]=1 and data_q[j+1]=0; 0 if there is no such j.
- Transition count = number of j in 0..DL_W-2 with data_q[j] != data_q[j+1].
- Both results are at most DL_W-1, so they fit 8 bits (DL_W<=128).
- Reset: data_q=0, o_valid=0, o_data=8'h00, state IDLE, latched ch/op=0.
- Reset asserted mid-capture or mid-hold aborts the operation. No byte is emitted.

## Timing
- Command byte at cycle N:
  - LOAD: data_q updated at N+1.
  - UNLOAD: o_valid=1 from N+1.
  - SAMPLE: window covers cycles N..N+CAP_WIN-1; back in IDLE at N+CAP_WIN.
  - EDGE/COUNT: EVAL at N+CAP_WIN; o_valid=1 and result on o_data from N+CAP_WIN+1.
- Valid arriving on the command cycle itself (cycle 0) is captured.
- Accept at cycle M while o_valid=1: o_valid=0 and the shifted o_data visible at M+1. A new command is accepted from M+1.
- Full word readout takes DL_W/8 UNLOAD/accept pairs. The top byte is zero after DL_W/8 shifts.
- i_valid and i_accept in the same cycle while in HOLD: the accept is processed and the command is dropped.

## Structure
- Package dl_sampler_pkg holds:
  - the opcode enum (OP_LOAD..OP_COUNT);
  - the state enum (IDLE, CAP, EVAL, HOLD);
  - a function clog2-safe width for the window counter.
- Sub-module dl_sampler_reduce is purely combinational and parametrised by DL_W. It takes data_q and outputs the 8-bit edge position and 8-bit transition count.
- The top level holds the FSM, window counter, channel mux and data register.

## Test plan
- Reset, then LOAD args 8,7,6,5,4,3,2,1 (bytes 0x80..0x10), then 4× UNLOAD/accept -> o_data 0x87, 0x65, 0x43, 0x21, then 0x00.
- SAMPLE ch=2, i_dl_valid[2] pulsed at cycle 1 with 0xDEADBEEF and at cycle 1+1 with 0x12345678 (CAP_WIN=2) -> readout 0xDEADBEEF; channel 1 valid alone -> data unchanged.
- EDGE ch=0 with sample 0x0000FFFF -> o_valid at N+3, o_data=0x10; sample 0xFFFFFFFF -> 0x00; sample 0x00000001 -> 0x01.
- COUNT ch=3 with sample 0x0F0F0F0F -> o_data=0x07; sample 0xAAAAAAAA -> 0x1F.
- While in HOLD, send LOAD and SAMPLE -> data_q and o_data unchanged; accept then LOAD -> applied. arg=7 with NUM_CH=4 -> dropped.
- Assert i_rst during CAP and during HOLD -> o_valid=0, o_data=0x00 next cycle, FSM in IDLE, subsequent UNLOAD returns 0x00.
